// File: rtl/su_fetch_seq.sv
// su_fetch_seq -- instruction fetch/sequencing stage in front of the MX11SU
// ISA decode ROM.
//
// Fetches opcode bytes from instruction memory into the instruction register,
// drives the ROM controls (fetch, insr_le, insr, ce_n), and runs B-class
// (load/store) instructions as data-bus transactions. It stops on the halt
// opcode, raises a sticky bus error when a handshake times out, and counts
// retired instructions.
//
// Optional feature: define SU_SINGLE_STEP_EN to add the `step` input. With
// run=0, a rising edge of step while IDLE runs exactly one instruction and
// then returns to IDLE. Without the macro, IDLE is left only on run=1.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   run          in   1 = sequencer may start/continue fetching
//   step         in   single-step request (SU_SINGLE_STEP_EN only)
//   imem_req     out  instruction-fetch request
//   imem_rdata   in   instruction byte, valid with imem_rvalid
//   imem_rvalid  in   fetch data valid
//   dmem_req     out  data-bus request for B-class instructions
//   dmem_we      out  1 = store, 0 = load (valid with dmem_req)
//   dmem_ack     in   data-bus transfer complete
//   fetch        out  ROM fetch phase
//   insr_le      out  ROM INSP load enable (one pulse per accepted byte)
//   insr         out  instruction register
//   ce_n         out  ROM active-low decode enable
//   halted       out  sequencer is halted
//   bus_err      out  sticky handshake-timeout flag
//   icount       out  retired-instruction count (wraps)
module su_fetch_seq #(
  parameter logic [7:0]  HALT_OPCODE = 8'hFF,
  parameter int unsigned TIMEOUT     = 255,
  parameter int unsigned ICNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
`ifdef SU_SINGLE_STEP_EN
  input  logic              step,
`endif
  output logic              imem_req,
  input  logic [7:0]        imem_rdata,
  input  logic              imem_rvalid,
  output logic              dmem_req,
  output logic              dmem_we,
  input  logic              dmem_ack,
  output logic              fetch,
  output logic              insr_le,
  output logic [7:0]        insr,
  output logic              ce_n,
  output logic              halted,
  output logic              bus_err,
  output logic [ICNT_W-1:0] icount
);

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, HALT} state_t;

  // The timeout fires on the TIMEOUT-th consecutive wait cycle, i.e. when the
  // counter already holds TIMEOUT-1 and the handshake is still missing.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt;
  logic       timeout_hit;
  logic       start;
  logic       load_insr, retire, set_err, wait_inc;

  assign timeout_hit = (wait_cnt == TIMEOUT_LAST);

`ifdef SU_SINGLE_STEP_EN
  // step is edge-sensitive; step_q tracks it in every state so an edge that
  // happens mid-instruction cannot fire later on return to IDLE.
  logic step_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) step_q <= 1'b0;
    else        step_q <= step;
  end

  // A stepped instruction needs no extra bookkeeping: with run=0 the normal
  // completion path already returns to IDLE.
  assign start = run | (step & ~step_q);
`else
  assign start = run;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      insr     <= 8'h00;
      icount   <= '0;
      wait_cnt <= 8'h00;
      bus_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load_insr) insr <= imem_rdata;
      if (retire)    icount <= icount + 1'b1;
      if (set_err)   bus_err <= 1'b1;
      // Counter is only non-zero while a handshake is outstanding, so every
      // FETCH/MEM visit starts counting from zero.
      if (wait_inc)  wait_cnt <= wait_cnt + 8'd1;
      else           wait_cnt <= 8'h00;
    end
  end

  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    fetch     = 1'b0;
    insr_le   = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ce_n      = 1'b1;
    halted    = 1'b0;
    load_insr = 1'b0;
    retire    = 1'b0;
    set_err   = 1'b0;
    wait_inc  = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        fetch    = 1'b1;
        ce_n     = 1'b0;
        // INSP must advance exactly once per accepted byte.
        insr_le  = imem_rvalid;
        if (imem_rvalid) begin
          load_insr = 1'b1;
          state_nxt = EXEC;
        end else if (timeout_hit) begin
          set_err   = 1'b1;
          state_nxt = HALT;
        end else begin
          wait_inc  = 1'b1;
        end
      end
      EXEC: begin
        // Halt is checked first so it wins even if HALT_OPCODE looks B-class.
        if (insr == HALT_OPCODE) begin
          state_nxt = HALT;
        end else if (insr[7:4] == 4'hB) begin
          state_nxt = MEM;
        end else begin
          ce_n      = 1'b0;
          retire    = 1'b1;
          state_nxt = run ? FETCH : IDLE;
        end
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = insr[3];
        if (dmem_ack) begin
          // ROM commits the load / drives store data in the ack cycle only.
          ce_n      = 1'b0;
          retire    = 1'b1;
          state_nxt = run ? FETCH : IDLE;
        end else if (timeout_hit) begin
          set_err   = 1'b1;
          state_nxt = HALT;
        end else begin
          wait_inc  = 1'b1;
        end
      end
      HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
